ca_search_ctrl: RTL



---
 rtl/ca_search_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ca_search_ctrl.sv
// Serial code-phase search sequencer: loads the PRN key, slews the code phase bin by bin and
// confirms detection over consecutive over-threshold code periods, or reports exhaustion.
module ca_search_ctrl #(
    parameter int STEP_HC = 2,
    parameter int CONFIRM = 3,
    parameter int MAG_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [9:0]       prn_key_in,
    input  logic [MAG_W-1:0] threshold,
    input  logic             dump_enable,
    input  logic             mag_valid,
    input  logic [MAG_W-1:0] mag,
    output logic             prn_key_enable,
    output logic [9:0]       prn_key,
    output logic             slew_enable,
    output logic [10:0]      code_slew,
    output logic             busy,
    output logic             found,
    output logic             fail,
    output logic [10:0]      bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic [2:0]       state_dbg
);

    localparam logic [10:0] STEP    = 11'(STEP_HC);
    localparam logic [3:0]  CONF_N  = 4'(CONFIRM);
    localparam logic [11:0] BIN_MAX = 12'd2045;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_EVAL    = 3'd3,
        S_SLEW    = 3'd4,
        S_SKIP    = 3'd5,
        S_CONFIRM = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [MAG_W-1:0] thr_q, thr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [9:0]       prn_key_d;
    logic [10:0]      bin_d;
    logic [MAG_W-1:0] peak_d;
    logic             found_d, fail_d;
    logic             key_en_d, slew_d, busy_d;
    logic [10:0]      code_slew_d;
    logic             hit;
    logic             bin_over;

    assign hit       = (mag >= thr_q);
    // Checked before the increment so bin can never pass the last legal offset.
    assign bin_over  = ({1'b0, bin} + {1'b0, STEP}) > BIN_MAX;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        cnt_d     = cnt_q;
        prn_key_d = prn_key;
        bin_d     = bin;
        peak_d    = peak_mag;
        found_d   = found;
        fail_d    = fail;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        prn_key_d = prn_key_in;
                        thr_d     = threshold;
                        found_d   = 1'b0;
                        fail_d    = 1'b0;
                        bin_d     = '0;
                        peak_d    = '0;
                        cnt_d     = '0;
                        state_d   = S_LOAD;
                    end
                end
                S_LOAD: state_d = S_SETTLE;
                S_SETTLE: begin
                    // The period in flight at load time is partial, so its magnitude is dropped.
                    if (dump_enable) state_d = S_EVAL;
                end
                S_EVAL: begin
                    if (mag_valid) begin
                        if (mag > peak_mag) peak_d = mag;
                        if (hit) begin
                            cnt_d = 4'd1;
                            if (CONF_N == 4'd1) begin
                                found_d = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_CONFIRM;
                            end
                        end else if (bin_over) begin
                            fail_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SLEW;
                        end
                    end
                end
                S_SLEW: begin
                    bin_d   = bin + STEP;
                    state_d = S_SKIP;
                end
                S_SKIP: begin
                    // This period straddles the slew and would smear the correlation.
                    if (mag_valid) state_d = S_EVAL;
                end
                S_CONFIRM: begin
                    if (mag_valid) begin
                        if (mag > peak_mag) peak_d = mag;
                        if (hit) begin
                            cnt_d = cnt_q + 4'd1;
                            if ((cnt_q + 4'd1) == CONF_N) begin
                                found_d = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            cnt_d = '0;
                            if (bin_over) begin
                                fail_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_SLEW;
                            end
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Pulses and status are derived from the next state so every output comes from a flop.
        key_en_d    = (state_d == S_LOAD);
        slew_d      = (state_d == S_SLEW);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        code_slew_d = busy_d ? STEP : 11'd0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            thr_q          <= '0;
            cnt_q          <= '0;
            prn_key        <= '0;
            bin            <= '0;
            peak_mag       <= '0;
            found          <= 1'b0;
            fail           <= 1'b0;
            prn_key_enable <= 1'b0;
            slew_enable    <= 1'b0;
            busy           <= 1'b0;
            code_slew      <= '0;
        end else begin
            thr_q          <= thr_d;
            cnt_q          <= cnt_d;
            prn_key        <= prn_key_d;
            bin            <= bin_d;
            peak_mag       <= peak_d;
            found          <= found_d;
            fail           <= fail_d;
            prn_key_enable <= key_en_d;
            slew_enable    <= slew_d;
            busy           <= busy_d;
            code_slew      <= code_slew_d;
        end
    end

endmodule
